// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, idle inserts a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               hold_i,
  input  logic               load_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;

  // pc/instr are left untouched on flush and bubble; only valid changes
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, one-outstanding fetch FSM, skid buffer and
// branch redirect handling, feeding the IF/ID register.
module if_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic               accept_s;
  logic               load_s;
  logic [INSTR_W-1:0] load_instr_s;
  logic [ADDR_W-1:0]  load_pc_s;

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign accept_s  = imem_req & imem_ready;
  assign load_pc_s = fetch_pc_q + ADDR_W'(PC_INC);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    skid_d       = skid_q;
    load_s       = 1'b0;
    load_instr_s = imem_rdata;
    case (state_q)
      FETCH: begin
        if (accept_s) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + ADDR_W'(PC_INC);
          state_d    = WAIT;
        end else begin
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (freeze) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            load_s  = 1'b1;
            state_d = FETCH;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (!freeze) begin
          load_s       = 1'b1;
          load_instr_s = skid_q;
          state_d      = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        state_d = imem_rvalid ? FETCH : DRAIN;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // A redirect overrides any load; a request already in flight must be drained
    if (branch_taken) begin
      pc_d   = {branch_address[ADDR_W-1:2], 2'b00};
      load_s = 1'b0;
      case (state_q)
        FETCH:   state_d = accept_s ? DRAIN : FETCH;
        WAIT:    state_d = imem_rvalid ? FETCH : DRAIN;
        HOLD:    state_d = FETCH;
        DRAIN:   state_d = imem_rvalid ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      load_s = load_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC[ADDR_W-1:0];
      fetch_pc_q <= '0;
      skid_q     <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      skid_q     <= skid_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_ni  (rst),
    .flush_i (branch_taken),
    .hold_i  (freeze),
    .load_i  (load_s),
    .pc_i    (load_pc_s),
    .instr_i (load_instr_s),
    .valid_o (if_id_valid),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr)
  );

endmodule
